// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic [ID_W-1:0]               grant_id,
    output logic                          grant_active,
    output logic                          locked,
    output logic                          timeout_err
);

    // Watchdog counter just wide enough to hold TIMEOUT_CYCLES-1.
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = TO_LAST[CNT_W-1:0];
    localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] wd_cnt;
    logic [ID_W-1:0]  winner;
    logic             winner_found;
    logic [ID_W-1:0]  sel_id;
    logic             sel_valid;
    logic             accept;
    logic             wd_expire;
    logic             timeout_hit;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        winner       = rr_ptr;
        winner_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!winner_found && req_valid[cand]) begin
                winner_found = 1'b1;
                winner       = ID_W'(cand);
            end
        end
    end

    // A held packet lock pins eligibility to the current owner only.
    always_comb begin
        sel_id    = locked ? grant_id : winner;
        sel_valid = locked ? req_valid[grant_id] : winner_found;
        accept    = (state == IDLE) && enable && sel_valid;
        wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == CNT_LAST);
    end

    // Same-cycle accept strobe; forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (accept && reset) begin
            req_ready[sel_id] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state plus the start pulse and watchdog abort strobe; done beats timeout.
    always_comb begin
        state_next  = state;
        tx_start    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_next = IDLE;
                end else if (wd_expire) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        timeout_err = timeout_hit;
    end

    // Grant bookkeeping: latch the accepted byte and owner, release on done or abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            locked       <= 1'b0;
            rr_ptr       <= PTR_INIT;
        end else begin
            if (accept) begin
                tx_data      <= req_data[int'(sel_id)*DATA_WIDTH +: DATA_WIDTH];
                grant_id     <= sel_id;
                grant_active <= 1'b1;
                rr_ptr       <= sel_id;
                locked       <= ~req_last[sel_id];
            end else if (state == WAIT_DONE && tx_done) begin
                grant_active <= 1'b0;
            end else if (timeout_hit) begin
                grant_active <= 1'b0;
                locked       <= 1'b0;
            end
        end
    end

    // Watchdog counts cycles spent in WAIT_DONE and restarts on every new wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (state == WAIT_DONE && state_next == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NR-1:0] req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [DW-1:0] tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          tx_done;
    logic [1:0]    grant_id;
    logic          grant_active;
    logic          locked;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;
    bit done_en = 1'b1;
    int done_delay = 3;

    int          acc_q[$];
    logic [15:0] start_q[$];
    int          to_q[$];

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .grant_active(grant_active), .locked(locked), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]        = v;
        req_data[i*DW +: DW] = d;
        req_last[i]         = l;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(|(req_ready & req_valid)) && n < 300);
        check({name, "_seen"}, |(req_ready & req_valid), 1);
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 300);
        check({name, "_seen"}, tx_start, 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_active && n < 300);
        check({name, "_idle"}, grant_active, 0);
    endtask

    // Transmitter model: frame-complete pulse done_delay cycles after each start.
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && done_en) begin
                repeat (done_delay) @(posedge clk);
                #1 tx_done = 1'b1;
                @(posedge clk);
                #1 tx_done = 1'b0;
            end
        end
    end

    // Monitor: pops expected accepts, starts and aborts as the DUT presents them.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            if (grant_active) check("ready_while_granted", req_ready, 0);
            if (|(req_ready & req_valid)) begin
                if (acc_q.size() == 0) unexpected("unexpected_accept", req_ready);
                else begin
                    int e;
                    e = acc_q.pop_front();
                    check("accept_id", oh_idx(req_ready), e);
                end
            end
            if (tx_start) begin
                if (start_q.size() == 0) unexpected("unexpected_tx_start", {grant_id, tx_data});
                else check("start_id_data", {6'd0, grant_id, tx_data}, start_q.pop_front());
            end
            if (timeout_err) begin
                if (to_q.size() == 0) unexpected("unexpected_timeout", grant_id);
                else check("timeout_id", grant_id, to_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        reset = 1'b0; enable = 1'b1; tx_busy = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0;
        set_req(0, 1, 8'h55, 1);
        set_req(2, 1, 8'h66, 1);

        // Reset state, with requests pending.
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_grant_active", grant_active, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout_err", timeout_err, 0);
        req_valid = '0;
        tick();
        reset = 1'b1;
        tick();

        // Round robin: all valid, single-byte frames -> 0,1,2,3,0.
        for (int i = 0; i < NR; i++) set_req(i, 1, 8'(8'h40 + i), 1);
        for (int k = 0; k < 5; k++) begin
            acc_q.push_back(k % NR);
            start_q.push_back({8'(k % NR), 8'(8'h40 + (k % NR))});
        end
        for (int k = 0; k < 5; k++) wait_accept("rr_accept");
        tick();
        req_valid = '0;
        wait_idle("rr");

        // Packet lock: requester 1 sends three bytes while 0 and 3 compete.
        tick();
        set_req(0, 1, 8'h70, 1);
        set_req(3, 1, 8'h73, 1);
        set_req(1, 1, 8'h11, 0);
        acc_q.push_back(1); acc_q.push_back(1); acc_q.push_back(1); acc_q.push_back(3);
        start_q.push_back(16'h0111); start_q.push_back(16'h0122);
        start_q.push_back(16'h0133); start_q.push_back(16'h0373);
        wait_accept("lock_b0");
        tick();
        check("lock_set_b0", locked, 1);
        req_valid[1] = 1'b0;
        repeat (30) tick();
        check("lock_hold_idle_active", grant_active, 0);
        check("lock_hold_idle_locked", locked, 1);
        set_req(1, 1, 8'h22, 0);
        wait_accept("lock_b1");
        tick();
        check("lock_set_b1", locked, 1);
        set_req(1, 1, 8'h33, 1);
        wait_accept("lock_b2");
        tick();
        check("lock_clear_b2", locked, 0);
        req_valid[1] = 1'b0;
        wait_accept("lock_next");
        tick();
        req_valid = '0;
        wait_idle("lock");

        // enable low: no grants even with a request pending.
        enable = 1'b0;
        set_req(2, 1, 8'hA5, 1);
        repeat (10) tick();
        @(negedge clk);
        check("disabled_no_ready", req_ready, 0);

        // Single byte from requester 2, frame completes 20 cycles after start.
        done_delay = 20;
        acc_q.push_back(2);
        start_q.push_back(16'h02A5);
        tick();
        enable = 1'b1;
        wait_accept("single");
        check("single_ready_same_cycle", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_start_next_cycle", tx_start, 1);
        check("single_tx_data", tx_data, 8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant_active && n < 100);
        check("single_active_fall_cycle", n, 21);
        check("single_grant_id", grant_id, 2);

        // tx_busy held 5 cycles after accept defers the start pulse.
        done_delay = 3;
        tick();
        tx_busy = 1'b1;
        set_req(0, 1, 8'h5A, 1);
        acc_q.push_back(0);
        start_q.push_back(16'h005A);
        wait_accept("busy");
        for (int k = 0; k < 5; k++) begin
            tick();
            req_valid = '0;
            @(negedge clk);
            check("busy_start_held", tx_start, 0);
        end
        tick();
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_start_released", tx_start, 1);
        @(negedge clk);
        check("busy_start_single", tx_start, 0);
        wait_idle("busy");

        // Watchdog: no tx_done, locked packet aborted, next requester granted.
        done_en = 1'b0;
        tick();
        set_req(1, 1, 8'h91, 0);
        set_req(2, 1, 8'h92, 1);
        acc_q.push_back(1); start_q.push_back(16'h0191);
        to_q.push_back(1);
        acc_q.push_back(2); start_q.push_back(16'h0292);
        wait_accept("wd");
        wait_start("wd_start");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 100);
        check("wd_latency", n, TO);
        check("wd_locked_before", locked, 1);
        done_en = 1'b1;
        @(negedge clk);
        check("wd_pulse_single", timeout_err, 0);
        check("wd_locked_cleared", locked, 0);
        check("wd_active_cleared", grant_active, 0);
        check("wd_next_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        wait_idle("wd_next");

        // Reset in WAIT_DONE clears everything at once; requester 0 wins afterwards.
        done_en = 1'b0;
        tick();
        set_req(3, 1, 8'hC3, 0);
        acc_q.push_back(3);
        start_q.push_back(16'h03C3);
        wait_accept("rst_mid");
        tick();
        req_valid = '0;
        wait_start("rst_mid_start");
        repeat (5) tick();
        check("rst_mid_active_before", grant_active, 1);
        reset = 1'b0;
        #1;
        check("rst_mid_tx_data", tx_data, 0);
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_grant_id", grant_id, 0);
        check("rst_mid_grant_active", grant_active, 0);
        check("rst_mid_locked", locked, 0);
        check("rst_mid_req_ready", req_ready, 0);
        for (int i = 0; i < NR; i++) set_req(i, 1, 8'(8'hE0 + i), 1);
        done_en = 1'b1;
        repeat (2) tick();
        acc_q.push_back(0);
        start_q.push_back(16'h00E0);
        reset = 1'b1;
        wait_accept("post_rst");
        tick();
        req_valid = '0;
        wait_idle("post_rst");

        repeat (5) tick();
        check("acc_q_drained", acc_q.size(), 0);
        check("start_q_drained", start_q.size(), 0);
        check("to_q_drained", to_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
